// File: rtl/jesd204_rx_align_pkg.sv
// Shared state encodings and helpers for the JESD204 RX alignment monitor.
package jesd204_rx_align_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED  = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_LOST      = 2'd3
    } align_state_e;

    // A configured multiframe count of 0 behaves as 1.
    function automatic logic [3:0] eff_count(input logic [3:0] cfg);
        return (cfg == 4'd0) ? 4'd1 : cfg;
    endfunction

endpackage

// File: rtl/jesd204_sat_counter.sv
// Saturating up-counter with clear; an increment coincident with clear restarts at 1.
module jesd204_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            if (clear) begin
                count <= WIDTH'(1);
            end else if (count != {WIDTH{1'b1}}) begin
                count <= count + WIDTH'(1);
            end
        end else if (clear) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/jesd204_rx_align_monitor.sv
// Per-lane lock/loss supervisor sampling the alignment error count once per LMFC.
// Optional peak-error tracking: define JESD204_RX_ALIGN_MONITOR_MAX_ERR_EN.
module jesd204_rx_align_monitor
    import jesd204_rx_align_pkg::*;
#(
    parameter int LOST_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      lmfc_edge,
    input  logic [7:0]                align_err_cnt,
    input  logic [7:0]                cfg_err_threshold,
    input  logic [3:0]                cfg_lock_mf_count,
    input  logic [3:0]                cfg_lost_mf_count,
    input  logic                      status_clear,
    output logic [1:0]                status_state,
    output logic                      realign_req,
    output logic                      irq_lost,
    output logic [LOST_CNT_WIDTH-1:0] status_lost_cnt,
    output logic [7:0]                status_max_err
);

    align_state_e state_q;
    logic [3:0]   good_cnt;
    logic [3:0]   bad_cnt;
    logic         sample;
    logic         mf_clean;
    logic         mf_bad;
    logic         lock_hit;
    logic         lost_hit;
    logic         lost_entry;

    assign sample   = enable && lmfc_edge &&
                      (state_q == ST_WAIT_LOCK || state_q == ST_LOCKED);
    assign mf_clean = (align_err_cnt == 8'd0);
    assign mf_bad   = (cfg_err_threshold != 8'd0) && (align_err_cnt >= cfg_err_threshold);

    // >= rather than == so a counter left above a reduced config still exits.
    assign lock_hit = ({1'b0, good_cnt} + 5'd1) >= {1'b0, eff_count(cfg_lock_mf_count)};
    assign lost_hit = ({1'b0, bad_cnt} + 5'd1) >= {1'b0, eff_count(cfg_lost_mf_count)};

    assign lost_entry = sample && (state_q == ST_LOCKED) && mf_bad && lost_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_DISABLED;
            good_cnt    <= 4'd0;
            bad_cnt     <= 4'd0;
            realign_req <= 1'b0;
        end else if (!enable) begin
            state_q     <= ST_DISABLED;
            good_cnt    <= 4'd0;
            bad_cnt     <= 4'd0;
            realign_req <= 1'b0;
        end else begin
            realign_req <= lost_entry;
            case (state_q)
                ST_DISABLED: state_q <= ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (lmfc_edge) begin
                        if (!mf_clean) begin
                            good_cnt <= 4'd0;
                        end else if (lock_hit) begin
                            good_cnt <= 4'd0;
                            state_q  <= ST_LOCKED;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (lmfc_edge) begin
                        if (!mf_bad) begin
                            bad_cnt <= 4'd0;
                        end else if (lost_hit) begin
                            bad_cnt <= 4'd0;
                            state_q <= ST_LOST;
                        end else begin
                            bad_cnt <= bad_cnt + 4'd1;
                        end
                    end
                end
                default: state_q <= ST_WAIT_LOCK;
            endcase
        end
    end

    assign status_state = state_q;

    // A loss event outranks a simultaneous status_clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_lost <= 1'b0;
        end else if (lost_entry) begin
            irq_lost <= 1'b1;
        end else if (status_clear) begin
            irq_lost <= 1'b0;
        end
    end

    jesd204_sat_counter #(
        .WIDTH(LOST_CNT_WIDTH)
    ) u_lost_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (lost_entry),
        .clear(status_clear),
        .count(status_lost_cnt)
    );

`ifdef JESD204_RX_ALIGN_MONITOR_MAX_ERR_EN
    logic [7:0] max_base;
    logic [7:0] max_err_q;

    assign max_base = status_clear ? 8'd0 : max_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            max_err_q <= 8'd0;
        end else if (sample && (align_err_cnt > max_base)) begin
            max_err_q <= align_err_cnt;
        end else begin
            max_err_q <= max_base;
        end
    end

    assign status_max_err = max_err_q;
`else
    assign status_max_err = 8'd0;
`endif

endmodule

// File: tb/tb_jesd204_rx_align_monitor.sv
// Scoreboard bench: a cycle model predicts outputs per driven cycle; a monitor compares.
module tb_jesd204_rx_align_monitor;

    localparam int LCW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           lmfc_edge;
    logic [7:0]     align_err_cnt;
    logic [7:0]     cfg_err_threshold;
    logic [3:0]     cfg_lock_mf_count;
    logic [3:0]     cfg_lost_mf_count;
    logic           status_clear;
    logic [1:0]     status_state;
    logic           realign_req;
    logic           irq_lost;
    logic [LCW-1:0] status_lost_cnt;
    logic [7:0]     status_max_err;

    typedef struct {
        int unsigned st;
        int unsigned req;
        int unsigned irq;
        int unsigned lost;
        int unsigned mx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int unsigned m_st, m_good, m_bad, m_irq, m_lost, m_max, m_req;

    always #5 clk = ~clk;

    jesd204_rx_align_monitor #(.LOST_CNT_WIDTH(LCW)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .lmfc_edge        (lmfc_edge),
        .align_err_cnt    (align_err_cnt),
        .cfg_err_threshold(cfg_err_threshold),
        .cfg_lock_mf_count(cfg_lock_mf_count),
        .cfg_lost_mf_count(cfg_lost_mf_count),
        .status_clear     (status_clear),
        .status_state     (status_state),
        .realign_req      (realign_req),
        .irq_lost         (irq_lost),
        .status_lost_cnt  (status_lost_cnt),
        .status_max_err   (status_max_err)
    );

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: next outputs from current model state and the driven inputs.
    task automatic model_step(input bit rst, input bit en, input bit edg,
                              input int unsigned err, input bit clr);
        int unsigned effl, effo, base;
        bit smp, entry;
        exp_t e;
        effl  = (cfg_lock_mf_count == 0) ? 1 : cfg_lock_mf_count;
        effo  = (cfg_lost_mf_count == 0) ? 1 : cfg_lost_mf_count;
        entry = 1'b0;
        if (rst) begin
            m_st = 0; m_good = 0; m_bad = 0; m_irq = 0; m_lost = 0; m_max = 0; m_req = 0;
        end else begin
            smp = en && edg && (m_st == 1 || m_st == 2);
`ifdef JESD204_RX_ALIGN_MONITOR_MAX_ERR_EN
            base  = clr ? 0 : m_max;
            m_max = (smp && err > base) ? err : base;
`else
            base  = 0;
            m_max = base;
`endif
            if (!en) begin
                m_st = 0; m_good = 0; m_bad = 0;
            end else if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 1) begin
                if (edg) begin
                    if (err != 0) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good >= effl) begin m_st = 2; m_good = 0; end
                    end
                end
            end else if (m_st == 2) begin
                if (edg) begin
                    if (cfg_err_threshold != 0 && err >= cfg_err_threshold) begin
                        m_bad++;
                        if (m_bad >= effo) begin m_st = 3; m_bad = 0; entry = 1'b1; end
                    end else m_bad = 0;
                end
            end else begin
                m_st = 1;
            end
            m_req = entry;
            if (entry) m_irq = 1;
            else if (clr) m_irq = 0;
            if (entry) m_lost = clr ? 1 : ((m_lost == (1 << LCW) - 1) ? m_lost : m_lost + 1);
            else if (clr) m_lost = 0;
        end
        e.st = m_st; e.req = m_req; e.irq = m_irq; e.lost = m_lost; e.mx = m_max;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst, input bit en, input bit edg,
                         input int unsigned err, input bit clr);
        @(negedge clk);
        reset         = rst;
        enable        = en;
        lmfc_edge     = edg;
        align_err_cnt = err[7:0];
        status_clear  = clr;
        model_step(rst, en, edg, err, clr);
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input bit en, input bit edg, input int unsigned err, input bit clr);
        drive(1'b0, en, edg, err, clr);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state", status_state, e.st);
            check("realign_req", realign_req, e.req);
            check("irq_lost", irq_lost, e.irq);
            check("lost_cnt", status_lost_cnt, e.lost);
            check("max_err", status_max_err, e.mx);
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; lmfc_edge = 1'b0; align_err_cnt = 8'd0;
        status_clear = 1'b0;
        cfg_err_threshold = 8'd4; cfg_lock_mf_count = 4'd3; cfg_lost_mf_count = 4'd2;

        drive(1'b1, 0, 0, 0, 0);
        drive(1'b1, 0, 0, 0, 0);
        check("reset_state", status_state, 0);
        check("reset_lost", status_lost_cnt, 0);

        // Lock acquisition with a restart on a dirty multiframe
        cyc(1, 0, 0, 0);
        check("wait_lock", status_state, 1);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 5, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        check("not_yet_locked", status_state, 1);
        cyc(1, 1, 0, 0);
        check("locked", status_state, 2);

        // Loss after two bad multiframes
        cyc(1, 1, 4, 0);
        cyc(1, 1, 4, 0);
        check("lost_state", status_state, 3);
        check("lost_req", realign_req, 1);
        check("lost_irq", irq_lost, 1);
        check("lost_cnt1", status_lost_cnt, 1);
        cyc(1, 1, 9, 0);
        check("back_wait", status_state, 1);
        check("req_dropped", realign_req, 0);

        // Relock, then hysteresis: alternating bad/tolerated errors
        repeat (3) cyc(1, 1, 0, 0);
        check("relocked", status_state, 2);
        cyc(1, 1, 4, 0); cyc(1, 1, 3, 0); cyc(1, 1, 4, 0); cyc(1, 1, 3, 0);
        check("hyst_locked", status_state, 2);

        // Enable low: DISABLED next cycle, sticky irq retained
        cyc(0, 1, 4, 0);
        check("disabled", status_state, 0);
        check("irq_retained", irq_lost, 1);

        // Threshold 0 disables loss detection
        cfg_err_threshold = 8'd0; cfg_lock_mf_count = 4'd0;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (20) cyc(1, 1, 255, 0);
        check("thr0_locked", status_state, 2);

        // status_clear coincident with LOST entry
        cyc(0, 0, 0, 0);
        cfg_err_threshold = 8'd4; cfg_lost_mf_count = 4'd0;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 4, 1);
        check("clr_irq", irq_lost, 1);
        check("clr_cnt", status_lost_cnt, 1);

        // Peak error tracking
        cyc(0, 0, 0, 1);
        check("max_cleared", status_max_err, 0);
        cfg_err_threshold = 8'd0;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 7, 0); cyc(1, 1, 200, 0); cyc(1, 1, 3, 0);
`ifdef JESD204_RX_ALIGN_MONITOR_MAX_ERR_EN
        check("max_err_200", status_max_err, 200);
`else
        check("max_err_off", status_max_err, 0);
`endif

        // Saturation of the loss counter
        cyc(0, 0, 0, 0);
        cfg_err_threshold = 8'd1; cfg_lock_mf_count = 4'd1; cfg_lost_mf_count = 4'd1;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < (1 << LCW) + 2; i++) begin
            cyc(1, 1, 0, 0);
            cyc(1, 1, 1, 0);
            cyc(1, 0, 0, 0);
        end
        check("lost_saturated", status_lost_cnt, (1 << LCW) - 1);

        // Reset mid-operation
        cyc(1, 1, 0, 0);
        drive(1'b1, 1, 0, 0, 0);
        check("rst_state", status_state, 0);
        check("rst_irq", irq_lost, 0);
        check("rst_lost", status_lost_cnt, 0);
        check("rst_max", status_max_err, 0);
        drive(1'b0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
